// File: rtl/toggle_rx.sv
// Receiver for toggle-encoded events from another clock domain: synchronizes the
// level, strobes once per transition and queues events in a saturating counter.
module toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_in,
  output logic             level,
  output logic             pulse,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] pend,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] MAX       = '1;
  localparam int               WARM_W    = 3;
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;
  logic [WARM_W-1:0]      r_warm;
  logic                   w_det;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_pend;
  logic [CNT_W-1:0]       w_pend_nxt;
  logic                   r_ev_valid;
  logic                   r_ovf;
  logic                   w_ovf_nxt;
  logic                   w_accept;
  logic                   w_drop;

  function automatic logic [CNT_W-1:0] pend_inc(input logic [CNT_W-1:0] p);
    return (p == MAX) ? MAX : p + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] pend_dec(input logic [CNT_W-1:0] p);
    return (p == '0) ? '0 : p - CNT_W'(1);
  endfunction

  // Stage: synchronizer chain, edge detect and registered strobe
  assign w_det = (r_sync[SYNC_STAGES-1] != r_prev) && (r_warm == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
      r_warm  <= WARM_LOAD;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], t_in};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_pulse <= w_det;
      if (r_warm != '0) r_warm <= r_warm - WARM_W'(1);
    end
  end

  // Stage: pending-event FSM; a strobe and an accept in the same cycle cancel out
  always_comb begin
    w_accept    = r_ev_valid & ev_ready;
    w_drop      = 1'b0;
    w_pend_nxt  = r_pend;
    w_state_nxt = r_state;
    if (r_pulse && !w_accept) begin
      if (r_state == FULL) begin
        w_drop = 1'b1;
      end else begin
        w_pend_nxt  = pend_inc(r_pend);
        w_state_nxt = (w_pend_nxt == MAX) ? FULL : HOLD;
      end
    end else if (w_accept && !r_pulse) begin
      w_pend_nxt  = pend_dec(r_pend);
      w_state_nxt = (w_pend_nxt == '0) ? EMPTY : HOLD;
    end
    w_ovf_nxt = w_drop | (r_ovf & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= EMPTY;
      r_pend     <= '0;
      r_ev_valid <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_ev_valid <= (w_state_nxt != EMPTY);
      r_ovf      <= w_ovf_nxt;
    end
  end

  assign level    = r_sync[SYNC_STAGES-1];
  assign pulse    = r_pulse;
  assign ev_valid = r_ev_valid;
  assign pend     = r_pend;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_toggle_rx.sv
// Randomized and directed bench for toggle_rx with a scoreboard of expected strobe
// cycles and an event-count reference model.
module tb_toggle_rx;
  localparam int SS   = 2;
  localparam int CW   = 4;
  localparam int MAXP = (1 << CW) - 1;
  localparam int HN   = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          t_in = 1'b0;
  logic          ev_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          level;
  logic          pulse;
  logic          ev_valid;
  logic [CW-1:0] pend;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  toggle_rx #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .t_in(t_in), .level(level), .pulse(pulse),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: edges counted from reset release; s_arr[k] is t_in seen at edge k.
  // A change between edges k-1 and k (k>=2) yields a strobe visible after edge k+SS.
  int cyc = 0;
  bit s_arr[0:HN-1];
  bit sched[0:HN-1];
  int sb_q[$];
  int m_pend = 0;
  bit m_ovf = 1'b0;
  bit m_p, m_acc, m_drop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0;
      m_pend = 0;
      m_ovf = 1'b0;
      sb_q.delete();
      for (int i = 0; i < HN; i++) begin
        s_arr[i] = 1'b0;
        sched[i] = 1'b0;
      end
    end else if (cyc < HN - SS - 2) begin
      cyc++;
      m_p    = sched[cyc-1];
      m_acc  = (m_pend > 0) && ev_ready;
      m_drop = 1'b0;
      if (m_p && !m_acc) begin
        if (m_pend == MAXP) m_drop = 1'b1;
        else m_pend++;
      end else if (m_acc && !m_p) begin
        m_pend--;
      end
      m_ovf = m_drop | (m_ovf & !ovf_clr);
      s_arr[cyc] = t_in;
      if (cyc >= 2 && s_arr[cyc] != s_arr[cyc-1]) begin
        sched[cyc+SS] = 1'b1;
        sb_q.push_back(cyc + SS);
      end
    end
  end

  // Monitor: every cycle compare outputs with the model, popping due strobes
  always @(negedge clk) begin : mon
    int li;
    bit exp_p;
    if (reset) begin
      li = cyc - SS + 1;
      chk("level", int'(level), (li >= 1) ? int'(s_arr[li]) : 0);
      exp_p = (sb_q.size() > 0) && (sb_q[0] == cyc);
      chk("pulse", int'(pulse), int'(exp_p));
      if (exp_p) void'(sb_q.pop_front());
      chk("pend", int'(pend), m_pend);
      chk("ev_valid", int'(ev_valid), int'(m_pend > 0));
      chk("ovf", int'(ovf), int'(m_ovf));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic toggles(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      t_in = ~t_in;
      cycles(gap);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen;
    int gap;

    // t_in high through reset: no event during warm-up, then 1->0 gives one event
    t_in = 1'b1;
    #1;
    chk("reset_pend", int'(pend), 0);
    chk("reset_valid", int'(ev_valid), 0);
    chk("reset_level", int'(level), 0);
    do_reset();
    cycles(20);
    chk("held_high_pend", int'(pend), 0);
    t_in = 1'b0;
    cycles(6);
    chk("fall_event_pend", int'(pend), 1);

    // Latency of a 0->1 transition
    t_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lat_level", int'(level), 1);
    chk("lat_pulse_early", int'(pulse), 0);
    @(posedge clk);
    #1;
    chk("lat_pulse", int'(pulse), 1);
    @(posedge clk);
    #1;
    chk("lat_pulse_end", int'(pulse), 0);
    chk("lat_pend", int'(pend), 2);
    chk("lat_valid", int'(ev_valid), 1);

    // Fill to FULL, then overflow
    do_reset();
    ev_ready = 1'b0;
    toggles(15, 4);
    chk("fill_pend15", int'(pend), MAXP);
    chk("fill_ovf0", int'(ovf), 0);
    toggles(1, 4);
    chk("ovf_pend15", int'(pend), MAXP);
    chk("ovf_set", int'(ovf), 1);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", int'(ovf), 0);

    // Strobe and accept in the same cycle while FULL
    t_in = ~t_in;
    repeat (SS + 1) @(posedge clk);
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    cycles(2);
    chk("coinc_pend", int'(pend), MAXP);
    chk("coinc_ovf", int'(ovf), 0);

    // Drop coinciding with ovf_clr: set wins
    t_in = ~t_in;
    repeat (SS + 1) @(posedge clk);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    cycles(1);
    chk("set_wins_ovf", int'(ovf), 1);
    chk("set_wins_pend", int'(pend), MAXP);

    // Drain 3 events
    do_reset();
    toggles(3, 4);
    chk("drain_start", int'(pend), 3);
    ev_ready = 1'b1;
    @(posedge clk); #1 chk("drain_2", int'(pend), 2);
    @(posedge clk); #1 chk("drain_1", int'(pend), 1);
    @(posedge clk); #1 chk("drain_0", int'(pend), 0);
    chk("drain_valid", int'(ev_valid), 0);
    cycles(3);
    chk("no_underflow", int'(pend), 0);
    ev_ready = 1'b0;

    // Randomized traffic: slow then fast consumer
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      gap = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        gap++;
        if (gap >= 3 && $urandom_range(0, 2) == 0) begin
          t_in = ~t_in;
          gap = 0;
        end
        ev_ready = (ph == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
        ovf_clr  = ($urandom_range(0, 31) == 0);
      end
    end
    ev_ready = 1'b0;
    ovf_clr = 1'b0;
    cycles(8);
    chk("rand_sb_empty", sb_q.size(), 0);

    // Asynchronous reset mid-cycle with pending events and overflow
    do_reset();
    toggles(18, 3);
    cycles(3);
    ev_ready = 1'b1;
    cycles(10);
    ev_ready = 1'b0;
    cycles(1);
    chk("pre_rst_pend", int'(pend), 5);
    chk("pre_rst_ovf", int'(ovf), 1);
    t_in = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_pend", int'(pend), 0);
    chk("async_ovf", int'(ovf), 0);
    chk("async_valid", int'(ev_valid), 0);
    chk("async_pulse", int'(pulse), 0);
    #2 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (pulse) seen = 1'b1;
    end
    chk("warmup_no_pulse", int'(seen), 0);
    chk("warmup_pend", int'(pend), 0);

    cycles(4);
    chk("final_sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
